// File: rtl/neuron_pkg.sv
// Shared types and constants for the time-multiplexed neuron scheduler.
package neuron_pkg;

    typedef logic signed [15:0] potential_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT      = 2'd2,
        S_WRITEBACK = 2'd3
    } state_t;

    localparam potential_t V_REST         = -16'sd65;
    localparam potential_t V_RESET        = -16'sd70;
    localparam potential_t DEFAULT_THRESH = 16'sd30;

endpackage

// File: rtl/neuron_state_bank.sv
// Per-neuron storage: membrane potential, input current and refractory count.
// One combinational read port and one update write port for the scheduler; currents load from cfg.
module neuron_state_bank
    import neuron_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int AW        = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_v,
    output logic [15:0]   rd_i,
    output logic [3:0]    rd_refr,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_v,
    input  logic [3:0]    wr_refr,
    input  logic          cur_we,
    input  logic [AW-1:0] cur_addr,
    input  logic [15:0]   cur_data
);

    potential_t v_mem [N_NEURONS];
    potential_t i_reg [N_NEURONS];
    logic [3:0] refr  [N_NEURONS];

    // Reads see the pre-edge contents, so a same-cycle current write issues the old value.
    assign rd_v    = v_mem[rd_addr];
    assign rd_i    = i_reg[rd_addr];
    assign rd_refr = refr[rd_addr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                v_mem[k] <= V_REST;
                i_reg[k] <= '0;
                refr[k]  <= '0;
            end
        end else begin
            if (wr_en) begin
                v_mem[wr_addr] <= potential_t'(wr_v);
                refr[wr_addr]  <= wr_refr;
            end
            if (cur_we) begin
                i_reg[cur_addr] <= potential_t'(cur_data);
            end
        end
    end

endmodule

// File: rtl/neuron_scheduler.sv
// Sweeps N_NEURONS neurons through one shared update datapath per tick.
// Define NEURON_SCHED_WDOG_EN to add a WAIT-state timeout of WDOG_CYC cycles.
module neuron_scheduler
    import neuron_pkg::*;
#(
    parameter int N_NEURONS    = 4,
    parameter int REFRAC_TICKS = 3,
    parameter int WDOG_CYC     = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        cfg_we,
    input  logic [4:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    output logic        dp_start,
    output logic [15:0] dp_v,
    output logic [15:0] dp_i,
    input  logic        dp_done,
    input  logic [15:0] dp_v_next,
    output logic        spike_valid,
    output logic [3:0]  spike_idx,
    output logic        busy,
    output logic        sweep_done,
    output logic        overrun,
    output logic [1:0]  fsm_state
);

    localparam int AW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [AW-1:0] LAST = AW'(N_NEURONS - 1);

    state_t        state;
    logic [AW-1:0] idx;
    potential_t    threshold;
    potential_t    v_next_q;
    logic [15:0]   rd_v, rd_i;
    logic [3:0]    rd_refr;
    logic          wr_en;
    logic [15:0]   wr_v;
    logic [3:0]    wr_refr;
    logic          cur_we, thr_we, spike_hit, at_last;

`ifdef NEURON_SCHED_WDOG_EN
    localparam int WW = $clog2(WDOG_CYC + 1);
    logic [WW-1:0] wdog_cnt;
`endif

    assign cur_we    = cfg_we && (cfg_addr < 5'(N_NEURONS));
    assign thr_we    = cfg_we && (cfg_addr == 5'(N_NEURONS));
    assign spike_hit = (v_next_q >= threshold);
    assign at_last   = (idx == LAST);

    assign dp_start  = (state == S_ISSUE) && (rd_refr == 4'd0);
    assign dp_v      = dp_start ? rd_v : '0;
    assign dp_i      = dp_start ? rd_i : '0;
    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    neuron_state_bank #(.N_NEURONS(N_NEURONS), .AW(AW)) u_bank (
        .clock    (clock),
        .reset    (reset),
        .rd_addr  (idx),
        .rd_v     (rd_v),
        .rd_i     (rd_i),
        .rd_refr  (rd_refr),
        .wr_en    (wr_en),
        .wr_addr  (idx),
        .wr_v     (wr_v),
        .wr_refr  (wr_refr),
        .cur_we   (cur_we),
        .cur_addr (cfg_addr[AW-1:0]),
        .cur_data (cfg_data)
    );

    always_comb begin
        wr_en   = 1'b0;
        wr_v    = rd_v;
        wr_refr = rd_refr;
        if (state == S_ISSUE && rd_refr != 4'd0) begin
            wr_en   = 1'b1;
            wr_refr = rd_refr - 4'd1;
        end else if (state == S_WRITEBACK) begin
            wr_en = 1'b1;
            if (spike_hit) begin
                wr_v    = V_RESET;
                wr_refr = 4'(REFRAC_TICKS);
            end else begin
                wr_v = v_next_q;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            threshold <= DEFAULT_THRESH;
        end else if (thr_we) begin
            threshold <= potential_t'(cfg_data);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            v_next_q    <= '0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
            sweep_done  <= 1'b0;
            overrun     <= 1'b0;
`ifdef NEURON_SCHED_WDOG_EN
            wdog_cnt    <= '0;
`endif
        end else begin
            spike_valid <= 1'b0;
            sweep_done  <= 1'b0;
            // The IDLE cycle that shows sweep_done still counts as busy for tick acceptance.
            if (tick && (state != S_IDLE || sweep_done)) overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (tick && !sweep_done) begin
                        idx   <= '0;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (rd_refr == 4'd0) begin
                        state <= S_WAIT;
`ifdef NEURON_SCHED_WDOG_EN
                        wdog_cnt <= '0;
`endif
                    end else begin
                        sweep_done <= at_last;
                        state      <= at_last ? S_IDLE : S_ISSUE;
                        idx        <= at_last ? idx : idx + AW'(1);
                    end
                end
                S_WAIT: begin
                    if (dp_done) begin
                        v_next_q <= potential_t'(dp_v_next);
                        state    <= S_WRITEBACK;
                    end
`ifdef NEURON_SCHED_WDOG_EN
                    else if (wdog_cnt == WW'(WDOG_CYC - 1)) begin
                        overrun    <= 1'b1;
                        sweep_done <= at_last;
                        state      <= at_last ? S_IDLE : S_ISSUE;
                        idx        <= at_last ? idx : idx + AW'(1);
                    end else begin
                        wdog_cnt <= wdog_cnt + WW'(1);
                    end
`endif
                end
                S_WRITEBACK: begin
                    if (spike_hit) begin
                        spike_valid <= 1'b1;
                        spike_idx   <= 4'(idx);
                    end
                    sweep_done <= at_last;
                    state      <= at_last ? S_IDLE : S_ISSUE;
                    idx        <= at_last ? idx : idx + AW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_scheduler.sv
// Directed bench for neuron_scheduler with an echoing datapath model (dp_v + dp_i, one-cycle latency).
module tb_neuron_scheduler;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        tick     = 1'b0;
    logic        cfg_we   = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic        dp_start;
    logic [15:0] dp_v, dp_i;
    logic        dp_done   = 1'b0;
    logic [15:0] dp_v_next = '0;
    logic        spike_valid;
    logic [3:0]  spike_idx;
    logic        busy, sweep_done, overrun;
    logic [1:0]  fsm_state;

    bit          dp_en = 1'b1;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          start_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [15:0] start_v_q[$];
    logic [15:0] start_i_q[$];
    logic [3:0]  spike_q[$];
    logic [3:0]  exp_q[$];

    neuron_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .dp_start    (dp_start),
        .dp_v        (dp_v),
        .dp_i        (dp_i),
        .dp_done     (dp_done),
        .dp_v_next   (dp_v_next),
        .spike_valid (spike_valid),
        .spike_idx   (spike_idx),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .overrun     (overrun),
        .fsm_state   (fsm_state)
    );

    // clock / reset
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=%0d expected=finish", cyc);
        $fatal(1, "simulation time limit reached");
    end

    // datapath model: answers one cycle after dp_start
    always @(posedge clock) begin
        dp_done <= 1'b0;
        if (dp_start && dp_en) begin
            dp_done   <= 1'b1;
            dp_v_next <= dp_v + dp_i;
        end
    end

    // monitor
    always @(negedge clock) begin
        if (dp_start) begin
            start_cnt++;
            start_v_q.push_back(dp_v);
            start_i_q.push_back(dp_i);
        end
        if (spike_valid) spike_q.push_back(spike_idx);
        if (sweep_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic clear_mon();
        #1;
        start_cnt = 0;
        start_v_q.delete();
        start_i_q.delete();
        spike_q.delete();
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [15:0] d);
        @(negedge clock);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clock);
        cfg_we   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic run_sweep(output int latency);
        int prev, t0;
        clear_mon();
        prev = done_cnt;
        @(negedge clock);
        tick = 1'b1;
        t0   = cyc;
        @(negedge clock);
        tick = 1'b0;
        latency = -1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clock);
            if (done_cnt != prev) begin
                latency = done_cyc - t0;
                break;
            end
        end
        repeat (2) @(posedge clock);
    endtask

    task automatic check_spikes(input string tag);
        check({tag, "_count"}, spike_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            logic [3:0] e;
            logic [3:0] o;
            e = exp_q.pop_front();
            o = (spike_q.size() > 0) ? spike_q.pop_front() : 4'hF;
            check({tag, "_idx"}, int'(o), int'(e));
        end
    endtask

    initial begin
        int lat, prev;

        // reset state
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_dp_start", dp_start, 0);
        check("rst_dp_v", dp_v, 0);
        check("rst_dp_i", dp_i, 0);
        check("rst_spike", spike_valid, 0);
        check("rst_sweep_done", sweep_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_state", fsm_state, 0);
        @(negedge clock);
        reset = 1'b1;

        // out-of-range address must not reach the threshold
        cfg_write(5'd5, 16'h8000);
        run_sweep(lat);
        check("base_starts", start_cnt, 4);
        for (int k = 0; k < 4; k++) check("base_dp_v", int'($signed(start_v_q[k])), -65);
        check("base_spikes", spike_q.size(), 0);
        check("base_latency", lat, 13);

        // neuron 2 spikes, then sits out three ticks
        cfg_write(5'd2, 16'd100);
        run_sweep(lat);
        exp_q.push_back(4'd2);
        check_spikes("n2_spike");
        check("n2_dp_i", int'($signed(start_i_q[2])), 100);
        check("n2_latency", lat, 13);
        for (int t = 0; t < 3; t++) begin
            run_sweep(lat);
            check("refr_starts", start_cnt, 3);
            check("refr_latency", lat, 11);
            check("refr_spikes", spike_q.size(), 0);
        end
        run_sweep(lat);
        check("post_refr_starts", start_cnt, 4);
        check("post_refr_dp_v", int'($signed(start_v_q[2])), -70);
        // -70 + 100 lands exactly on the threshold of 30
        exp_q.push_back(4'd2);
        check_spikes("eq_thresh");
        check("no_overrun_yet", overrun, 0);

        // negative threshold: every neuron spikes
        do_reset();
        cfg_write(5'd4, 16'hFFBF);
        run_sweep(lat);
        for (int k = 0; k < 4; k++) exp_q.push_back(4'(k));
        check_spikes("all_spike");

        // tick while busy
        do_reset();
        clear_mon();
        prev = done_cnt;
        @(negedge clock);
        tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        repeat (3) @(negedge clock);
        check("ovr_before", overrun, 0);
        @(negedge clock);
        tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        repeat (40) @(posedge clock);
        check("ovr_sweeps", done_cnt - prev, 1);
        check("ovr_flag", overrun, 1);

        // reset during WAIT of neuron 1
        do_reset();
        check("ovr_cleared", overrun, 0);
        cfg_write(5'd0, 16'd10);
        @(negedge clock);
        tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        check("mid_wait_state", fsm_state, 2);
        prev = done_cnt;
        clear_mon();
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_state", fsm_state, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (20) @(posedge clock);
        check("abort_no_done", done_cnt - prev, 0);
        check("abort_no_spike", spike_q.size(), 0);
        run_sweep(lat);
        check("abort_v0", int'($signed(start_v_q[0])), -65);
        check("abort_i0", int'($signed(start_i_q[0])), 0);

`ifdef NEURON_SCHED_WDOG_EN
        // datapath never answers
        do_reset();
        dp_en = 1'b0;
        run_sweep(lat);
        check("wdog_latency", lat, 261);
        check("wdog_overrun", overrun, 1);
        check("wdog_starts", start_cnt, 4);
        check("wdog_spikes", spike_q.size(), 0);
        dp_en = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
